// File: rtl/timer_pkg.sv
// Shared types for the loadable countdown timer.
package timer_pkg;

    localparam int N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter / countdown timer with pause, resume and terminal-count pulse.
// Optional auto-reload on terminal count is enabled by defining DOWN_COUNTER_TIMER_AUTO_RELOAD_EN.
module down_counter_timer
    import timer_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         start,
    input  logic         pause,
    output logic [N-1:0] q,
    output logic         min_tick,
    output logic         busy,
    output logic         done,
    output logic         done_tick
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_t       state_q, state_d;
    logic [N-1:0] q_q, q_d;
    logic [N-1:0] reload_q, reload_d;
    logic         done_tick_q, done_tick_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            q_q         <= '0;
            reload_q    <= '0;
            done_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            reload_q    <= reload_d;
            done_tick_q <= done_tick_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        reload_d    = reload_q;
        done_tick_d = 1'b0;

        if (load) begin
            q_d      = load_val;
            reload_d = load_val;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start && (q_q != '0)) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else if (q_q == ONE) begin
                        q_d         = '0;
                        done_tick_d = 1'b1;
`ifndef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
                        state_d     = DONE;
`endif
                    end else if (q_q == '0) begin
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
                        // Zero was shown for one cycle; restart the period, or stop if nothing to reload.
                        if (reload_q != '0) begin
                            q_d = reload_q;
                        end else begin
                            state_d = DONE;
                        end
`else
                        state_d = DONE;
`endif
                    end else begin
                        q_d = q_q - ONE;
                    end
                end
                HOLD: begin
                    if (start && !pause) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign q         = q_q;
    assign done_tick = done_tick_q;
    assign min_tick  = (q_q == '0);
    assign busy      = (state_q == RUN) || (state_q == HOLD);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: vector table through a scoreboard queue,
// followed by hand-written latency and period sequences.
module tb_down_counter_timer;

    localparam int N = 8;
    localparam int W = N + 4;

    typedef struct {
        logic         rst;
        logic         ld;
        logic [N-1:0] lv;
        logic         st;
        logic         pa;
        logic [N-1:0] eq;
        logic         eb;
        logic         ed;
        logic         et;
    } vec_t;

    logic         clk;
    logic         reset;
    logic         load;
    logic [N-1:0] load_val;
    logic         start;
    logic         pause;
    logic [N-1:0] q;
    logic         min_tick;
    logic         busy;
    logic         done;
    logic         done_tick;

    logic [W-1:0] exp_q[$];
    vec_t         vecs[$];
    int           checks;
    int           errors;

    down_counter_timer #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_val  (load_val),
        .start     (start),
        .pause     (pause),
        .q         (q),
        .min_tick  (min_tick),
        .busy      (busy),
        .done      (done),
        .done_tick (done_tick)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic rst, input logic ld, input logic [N-1:0] lv,
                               input logic st, input logic pa, input logic [N-1:0] eq,
                               input logic eb, input logic ed, input logic et);
        vec_t r;
        r.rst = rst; r.ld = ld; r.lv = lv; r.st = st; r.pa = pa;
        r.eq = eq; r.eb = eb; r.ed = ed; r.et = et;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: apply one vector, push its expectation, compare after the edge.
    task automatic apply(input vec_t t, input int idx);
        logic [W-1:0] got;
        logic [W-1:0] want;
        @(negedge clk);
        reset    = t.rst;
        load     = t.ld;
        load_val = t.lv;
        start    = t.st;
        pause    = t.pa;
        exp_q.push_back({t.eq, t.eb, t.ed, t.et, (t.eq == '0)});
        @(posedge clk);
        #1;
        got  = {q, busy, done, done_tick, min_tick};
        want = exp_q.pop_front();
        check($sformatf("vec%0d {q,busy,done,tick,min}", idx), 32'(got), 32'(want));
    endtask

    task automatic idle_inputs();
        reset = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    endtask

    initial begin
        int cyc;
        checks = 0;
        errors = 0;
        reset = 1'b1; load = 1'b0; load_val = '0; start = 1'b0; pause = 1'b0;

        //            rst ld lv    st pa   q     b  d  t
        vecs.push_back(v(1, 0, 8'd0,  0, 0, 8'd0,  0, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  1, 0, 8'd0,  0, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  1, 0, 8'd0,  0, 0, 0));
        vecs.push_back(v(0, 1, 8'd5,  0, 0, 8'd5,  0, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  1, 0, 8'd5,  1, 0, 0));
`ifndef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd4,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd3,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd2,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd1,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd0,  0, 1, 1));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd0,  0, 1, 0));
        vecs.push_back(v(0, 0, 8'd0,  1, 0, 8'd0,  0, 1, 0));
        // Pause at 7 for three cycles, then resume
        vecs.push_back(v(0, 1, 8'd10, 0, 0, 8'd10, 0, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  1, 0, 8'd10, 1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd9,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd8,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd7,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 1, 8'd7,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 1, 8'd7,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  1, 1, 8'd7,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  1, 0, 8'd7,  1, 0, 0));
        for (int k = 6; k >= 1; k--) begin
            vecs.push_back(v(0, 0, 8'd0, 0, 0, 8'(k), 1, 0, 0));
        end
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd0,  0, 1, 1));
        // Load with start while running at 20
        vecs.push_back(v(0, 1, 8'd25, 0, 0, 8'd25, 0, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  1, 0, 8'd25, 1, 0, 0));
        for (int k = 24; k >= 20; k--) begin
            vecs.push_back(v(0, 0, 8'd0, 0, 0, 8'(k), 1, 0, 0));
        end
        vecs.push_back(v(0, 1, 8'd3,  1, 1, 8'd3,  0, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd3,  0, 0, 0));
        // Reset mid-count at 9
        vecs.push_back(v(0, 1, 8'd15, 0, 0, 8'd15, 0, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  1, 0, 8'd15, 1, 0, 0));
        for (int k = 14; k >= 9; k--) begin
            vecs.push_back(v(0, 0, 8'd0, 0, 0, 8'(k), 1, 0, 0));
        end
        vecs.push_back(v(1, 0, 8'd0,  0, 0, 8'd0,  0, 0, 0));
        vecs.push_back(v(1, 1, 8'd7,  1, 0, 8'd0,  0, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  1, 0, 8'd0,  0, 0, 0));
`else
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd4,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd3,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd2,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd1,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd0,  1, 0, 1));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd5,  1, 0, 0));
        // Reload of 3: sequence 3,2,1,0,3,2,1,0
        vecs.push_back(v(0, 1, 8'd3,  0, 0, 8'd3,  0, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  1, 0, 8'd3,  1, 0, 0));
        for (int r = 0; r < 2; r++) begin
            vecs.push_back(v(0, 0, 8'd0, 0, 0, 8'd2, 1, 0, 0));
            vecs.push_back(v(0, 0, 8'd0, 0, 0, 8'd1, 1, 0, 0));
            vecs.push_back(v(0, 0, 8'd0, 0, 0, 8'd0, 1, 0, 1));
            vecs.push_back(v(0, 0, 8'd0, 0, 0, 8'd3, 1, 0, 0));
        end
        vecs.push_back(v(0, 0, 8'd0,  0, 1, 8'd3,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  1, 0, 8'd3,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd2,  1, 0, 0));
        vecs.push_back(v(0, 1, 8'd0,  1, 0, 8'd0,  0, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  1, 0, 8'd0,  0, 0, 0));
        // Reload of 1 gives a period of two
        vecs.push_back(v(0, 1, 8'd1,  0, 0, 8'd1,  0, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  1, 0, 8'd1,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd0,  1, 0, 1));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd1,  1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,  0, 0, 8'd0,  1, 0, 1));
        vecs.push_back(v(1, 0, 8'd0,  0, 0, 8'd0,  0, 0, 0));
`endif
        // Full-scale load
        vecs.push_back(v(0, 1, 8'd255, 0, 0, 8'd255, 0, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,   1, 0, 8'd255, 1, 0, 0));
        vecs.push_back(v(0, 0, 8'd0,   0, 0, 8'd254, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);

        // Latency from the start edge to the terminal-count pulse, load of 6
        @(negedge clk);
        idle_inputs();
        load = 1'b1; load_val = 8'd6;
        @(negedge clk);
        load = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (done_tick !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("edges start->done_tick", 32'(cyc), 32'd7);
        check("q at terminal count", 32'(q), 32'd0);
`ifndef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
        check("done at terminal count", 32'(done), 32'd1);
        @(negedge clk);
        check("done_tick one cycle", 32'(done_tick), 32'd0);
        check("busy after done", 32'(busy), 32'd0);
        check("done held", 32'(done), 32'd1);
`else
        check("done stays low", 32'(done), 32'd0);
        @(negedge clk);
        check("done_tick one cycle", 32'(done_tick), 32'd0);
        check("q reloaded", 32'(q), 32'd6);
        cyc = 1;
        while (done_tick !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("reload period", 32'(cyc), 32'd7);
        check("done stays low in reload", 32'(done), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
